qar_imem_prefetch: RTL

- Instruction-fetch prefetch buffer between the core's external instruction port (imem_valid/imem_addr/imem_ready/imem_rdata, active when USE_INTERNAL_IMEM=0) and a pipelined instruction memory.
- Services the core's post-ICACHE miss traffic.
- Streams sequential words ahead of the fetch address into a small FIFO.
- Discards the stream on any non-sequential request, such as a branch or trap.

---
 rtl/qar_imem_prefetch.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/qar_imem_prefetch.sv
// Sequential instruction prefetch buffer between the core fetch port and a pipelined memory.
// Optional hit/miss statistics counters are built when QAR_PREFETCH_STATS_EN is defined.
module qar_imem_prefetch #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  imem_valid,
  input  logic [ADDR_WIDTH-1:0] imem_addr,
  output logic                  imem_ready,
  output logic [31:0]           imem_rdata,
  output logic                  mreq_valid,
  output logic [ADDR_WIDTH-1:0] mreq_addr,
  input  logic                  mreq_ready,
  input  logic                  mresp_valid,
  input  logic [31:0]           mresp_data,
  output logic [31:0]           stat_hits,
  output logic [31:0]           stat_misses
);

  localparam int unsigned PtrW  = $clog2(DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned DropW = CntW + 1;
  localparam logic [CntW-1:0]       DepthC  = CntW'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] WordInc = ADDR_WIDTH'(4);

  typedef enum logic [1:0] {StIdle, StResp, StWait} state_e;

  state_e                state_q, state_d;
  logic [31:0]           fifo_q [DEPTH];
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]       count_q, count_d, pending_q, pending_d, occupancy;
  logic [DropW-1:0]      drop_q, drop_d;
  logic [ADDR_WIDTH-1:0] head_addr_q, head_addr_d, fetch_addr_q, fetch_addr_d, req_aligned;
  logic                  stream_q, stream_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  req_accept, resp_drop, resp_write, head_match, pop, flush;
  logic                  unused_addr_lsb;

  assign unused_addr_lsb = ^imem_addr[1:0];
  assign req_aligned     = {imem_addr[ADDR_WIDTH-1:2], 2'b00};
  assign head_match      = imem_addr[ADDR_WIDTH-1:2] == head_addr_q[ADDR_WIDTH-1:2];

  assign occupancy  = count_q + pending_q;
  assign mreq_valid = stream_q && (occupancy < DepthC);
  assign mreq_addr  = fetch_addr_q;
  assign req_accept = mreq_valid && mreq_ready;
  assign resp_drop  = mresp_valid && (drop_q != '0);
  assign resp_write = mresp_valid && (drop_q == '0);

  assign imem_ready = (state_q == StResp);
  assign imem_rdata = rdata_q;

  always_comb begin
    state_d      = state_q;
    rdata_d      = rdata_q;
    head_addr_d  = head_addr_q;
    fetch_addr_d = req_accept ? fetch_addr_q + WordInc : fetch_addr_q;
    stream_d     = stream_q;
    pop          = 1'b0;
    flush        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (imem_valid) begin
          if ((count_q != '0) && head_match) begin
            pop     = 1'b1;
            state_d = StResp;
          end else if ((pending_q != '0) && head_match) begin
            state_d = StWait;
          end else begin
            flush        = 1'b1;
            head_addr_d  = req_aligned;
            fetch_addr_d = req_aligned;
            stream_d     = 1'b1;
            state_d      = StWait;
          end
        end
      end
      StWait: begin
        // An empty FIFO with a live response forwards the response straight to rdata.
        if ((count_q != '0) || resp_write) begin
          pop     = 1'b1;
          state_d = StResp;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (pop) begin
      rdata_d     = (count_q != '0) ? fifo_q[rd_ptr_q] : mresp_data;
      head_addr_d = head_addr_q + WordInc;
    end
  end

  always_comb begin
    count_d   = count_q;
    pending_d = pending_q;
    drop_d    = drop_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    if (flush) begin
      count_d   = '0;
      pending_d = '0;
      rd_ptr_d  = '0;
      wr_ptr_d  = '0;
      // Same-cycle response retires one pre-flush request; same-cycle accept adds one.
      drop_d    = drop_q + DropW'(pending_q) + DropW'(req_accept) - DropW'(mresp_valid);
    end else begin
      count_d   = count_q + CntW'(resp_write) - CntW'(pop);
      pending_d = pending_q + CntW'(req_accept) - CntW'(resp_write);
      drop_d    = drop_q - DropW'(resp_drop);
      if (resp_write) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)        rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (resp_write && !flush) fifo_q[wr_ptr_q] <= mresp_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      pending_q    <= '0;
      drop_q       <= '0;
      head_addr_q  <= '0;
      fetch_addr_q <= '0;
      stream_q     <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      pending_q    <= pending_d;
      drop_q       <= drop_d;
      head_addr_q  <= head_addr_d;
      fetch_addr_q <= fetch_addr_d;
      stream_q     <= stream_d;
      rdata_q      <= rdata_d;
    end
  end

`ifdef QAR_PREFETCH_STATS_EN
  logic        hit_evt, miss_evt;
  logic [31:0] hits_q, misses_q;

  assign hit_evt  = (state_q == StIdle) && imem_valid && head_match &&
                    ((count_q != '0) || (pending_q != '0));
  assign miss_evt = (state_q == StIdle) && imem_valid && !hit_evt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hits_q   <= '0;
      misses_q <= '0;
    end else begin
      if (hit_evt && (hits_q != '1))    hits_q   <= hits_q + 32'd1;
      if (miss_evt && (misses_q != '1)) misses_q <= misses_q + 32'd1;
    end
  end

  assign stat_hits   = hits_q;
  assign stat_misses = misses_q;
`else
  assign stat_hits   = '0;
  assign stat_misses = '0;
`endif

endmodule
